// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital clock setting path: field width, field
// limits, the setting-controller state encoding and small state helpers.
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int FIELD_W = 6;

  localparam logic [FIELD_W-1:0] HR_MAX  = 6'd23;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    IDLE,
    T_HR,
    T_MIN,
    T_SEC,
    T_LOAD,
    A_HR,
    A_MIN,
    A_LOAD
  } state_t;

  // States in which the user is editing a field (timeout and blink active).
  function automatic logic is_edit(state_t s);
    return (s == T_HR) || (s == T_MIN) || (s == T_SEC) ||
           (s == A_HR) || (s == A_MIN);
  endfunction

  // One-hot field select shown on the display: [2]=hour, [1]=min, [0]=sec.
  function automatic logic [2:0] field_of(state_t s);
    case (s)
      T_HR, A_HR:   return 3'b100;
      T_MIN, A_MIN: return 3'b010;
      T_SEC:        return 3'b001;
      default:      return 3'b000;
    endcase
  endfunction

  // Successor on btn_next; the last field of each sequence leads to its load.
  function automatic state_t next_field(state_t s);
    case (s)
      T_HR:    return T_MIN;
      T_MIN:   return T_SEC;
      T_SEC:   return T_LOAD;
      A_HR:    return A_MIN;
      A_MIN:   return A_LOAD;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wrap_inc.sv
// -----------------------------------------------------------------------------
// wrap_inc
// Combinational increment of one time field with wrap to zero at a limit.
//   value  : current field value
//   limit  : largest legal value of the field (23 or 59)
//   result : value + 1, or 0 when value is already at (or past) the limit
// -----------------------------------------------------------------------------
module wrap_inc
  import clock_pkg::*;
(
  input  logic [FIELD_W-1:0] value,
  input  logic [FIELD_W-1:0] limit,
  output logic [FIELD_W-1:0] result
);

  // ">=" rather than "==" so an out-of-range value still recovers to zero.
  assign result = (value >= limit) ? '0 : value + FIELD_W'(1);

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// User-setting controller for the digital clock. Turns single-cycle button
// pulses into a field-by-field edit of the time (h/m/s) or alarm (h/m) and
// drives the clock core's load bus and load/enable strobes.
//   clk, rst                 : system clock, synchronous active-low reset
//   btn_mode/next/inc/alm    : one-cycle button pulses
//   cur_sec/min/hour         : running time from the clock core
//   sec/min/hour             : load bus (the edit registers)
//   time_c, alm_c            : one-cycle time / alarm load strobes
//   alm_on, alm_off, alm_en  : alarm enable strobes and level
//   field, blink             : display field select and blink phase
// All outputs are registered.
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT   = 1000,
  parameter int BLINK_DIV = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_next,
  input  logic               btn_inc,
  input  logic               btn_alm,
  input  logic [FIELD_W-1:0] cur_sec,
  input  logic [FIELD_W-1:0] cur_min,
  input  logic [FIELD_W-1:0] cur_hour,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] hour,
  output logic               time_c,
  output logic               alm_c,
  output logic               alm_on,
  output logic               alm_off,
  output logic               alm_en,
  output logic [2:0]         field,
  output logic               blink
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int BL_W = $clog2(BLINK_DIV + 1);

  state_t             state, next_state;
  logic               do_inc;
  logic [FIELD_W-1:0] inc_val, inc_lim, inc_res;
  logic [FIELD_W-1:0] alm_hour, alm_min;
  logic [TO_W-1:0]    to_cnt;
  logic [BL_W-1:0]    bl_cnt;
  logic               any_btn, timed_out;

  assign any_btn   = btn_mode | btn_next | btn_inc | btn_alm;
  assign timed_out = is_edit(state) && !any_btn && (to_cnt == TO_W'(TIMEOUT - 1));

  // Next state: load states always fall back to IDLE and ignore buttons;
  // otherwise btn_mode beats btn_next beats btn_inc.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    next_state = state;
    do_inc     = 1'b0;
    if (state == T_LOAD || state == A_LOAD) begin
      next_state = IDLE;
    end else if (btn_mode) begin
      case (state)
        IDLE:               next_state = T_HR;
        T_HR, T_MIN, T_SEC: next_state = A_HR;
        default:            next_state = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (btn_next)       next_state = next_field(state);
      else if (btn_inc)   do_inc     = 1'b1;
      else if (timed_out) next_state = IDLE;
    end
  end

  // One shared incrementer; the registered field select steers it.
  always_comb begin
    inc_val = hour;
    inc_lim = HR_MAX;
    if (field[1]) begin
      inc_val = min;
      inc_lim = MIN_MAX;
    end else if (field[0]) begin
      inc_val = sec;
      inc_lim = SEC_MAX;
    end
  end

  wrap_inc u_wrap_inc (
    .value  (inc_val),
    .limit  (inc_lim),
    .result (inc_res)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: every register here has a defined reset value, including the
      // alarm shadow, so a reset mid-edit leaves nothing half-loaded.
      state    <= IDLE;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      alm_hour <= '0;
      alm_min  <= '0;
      time_c   <= 1'b0;
      alm_c    <= 1'b0;
      alm_on   <= 1'b0;
      alm_off  <= 1'b0;
      alm_en   <= 1'b0;
      field    <= '0;
      blink    <= 1'b0;
      to_cnt   <= '0;
      bl_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same
      // pre-edge values regardless of statement order.
      state  <= next_state;
      field  <= field_of(next_state);
      time_c <= (next_state == T_LOAD);
      alm_c  <= (next_state == A_LOAD);

      alm_on  <= 1'b0;
      alm_off <= 1'b0;
      if (state == IDLE && btn_alm && !btn_mode) begin
        alm_en  <= !alm_en;
        alm_on  <= !alm_en;
        alm_off <= alm_en;
      end

      // Edit registers: capture live time, load alarm shadow, or increment.
      if (state == IDLE && btn_mode) begin
        hour <= cur_hour;
        min  <= cur_min;
        sec  <= cur_sec;
      end else if (next_state == A_HR && state != A_HR) begin
        hour <= alm_hour;
        min  <= alm_min;
        sec  <= '0;
      end else if (do_inc) begin
        if (field[2]) hour <= inc_res;
        if (field[1]) min  <= inc_res;
        if (field[0]) sec  <= inc_res;
      end

      if (next_state == A_LOAD) begin
        alm_hour <= hour;
        alm_min  <= min;
      end

      if (!is_edit(state) || any_btn || timed_out) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + TO_W'(1);

      // Blink phase restarts on every state entry and stays low outside edits.
      if (next_state != state || !is_edit(next_state)) begin
        bl_cnt <= '0;
        blink  <= 1'b0;
      end else if (bl_cnt == BL_W'(BLINK_DIV - 1)) begin
        bl_cnt <= '0;
        blink  <= !blink;
      end else begin
        bl_cnt <= bl_cnt + BL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed bench for clock_set_ctrl with a behavioural model (edit mode,
// field index, plain modular arithmetic) compared on every falling edge, plus
// hand-computed literal expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  localparam int TIMEOUT   = 20;
  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_alm = 1'b0;
  logic [5:0] cur_sec = '0, cur_min = '0, cur_hour = '0;
  logic [5:0] sec, min, hour;
  logic       time_c, alm_c, alm_on, alm_off, alm_en, blink;
  logic [2:0] field;

  clock_set_ctrl #(
    .TIMEOUT   (TIMEOUT),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_next (btn_next),
    .btn_inc  (btn_inc),
    .btn_alm  (btn_alm),
    .cur_sec  (cur_sec),
    .cur_min  (cur_min),
    .cur_hour (cur_hour),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .time_c   (time_c),
    .alm_c    (alm_c),
    .alm_on   (alm_on),
    .alm_off  (alm_off),
    .alm_en   (alm_en),
    .field    (field),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // md: 0 idle, 1 time edit, 2 alarm edit; k: field index in edit order.
  int md = 0, k = 0, h = 0, mi = 0, s = 0, sh_h = 0, sh_m = 0, idle_n = 0, age = 0;
  bit loading = 0, e_en = 0, e_tc = 0, e_ac = 0, e_on = 0, e_off = 0;

  function automatic int exp_field();
    if (md == 0 || loading) return 0;
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  function automatic int exp_blink();
    if (md == 0 || loading) return 0;
    return (age / BLINK_DIV) % 2;
  endfunction

  function automatic void model_step(bit bm, bit bn, bit bi, bit ba, bit r);
    int  o_md, o_k;
    bit  o_ld;
    e_tc = 0; e_ac = 0; e_on = 0; e_off = 0;
    if (!r) begin
      md = 0; k = 0; loading = 0; h = 0; mi = 0; s = 0;
      sh_h = 0; sh_m = 0; e_en = 0; idle_n = 0; age = 0;
      return;
    end
    o_md = md; o_k = k; o_ld = loading;
    if (loading) begin
      loading = 0;
      md      = 0;
    end else if (md == 0) begin
      idle_n = 0;
      if (bm) begin
        md = 1; k = 0; h = cur_hour; mi = cur_min; s = cur_sec;
      end else if (ba) begin
        e_en = !e_en;
        if (e_en) e_on = 1; else e_off = 1;
      end
    end else begin
      if (bm) begin
        if (md == 1) begin
          md = 2; k = 0; h = sh_h; mi = sh_m; s = 0;
        end else begin
          md = 0;
        end
      end else if (bn) begin
        k++;
        if (k == ((md == 1) ? 3 : 2)) begin
          loading = 1;
          if (md == 1) e_tc = 1;
          else begin
            e_ac = 1; sh_h = h; sh_m = mi;
          end
        end
      end else if (bi) begin
        if (k == 0)      h  = (h + 1) % 24;
        else if (k == 1) mi = (mi + 1) % 60;
        else             s  = (s + 1) % 60;
      end
      if (bm || bn || bi || ba) idle_n = 0;
      else begin
        idle_n++;
        if (idle_n == TIMEOUT) begin
          md = 0; idle_n = 0;
        end
      end
    end
    if (md != o_md || k != o_k || loading != o_ld) age = 0;
    else age++;
  endfunction

  // ---------------- single compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("hour",    32'(hour),    h);
      check("min",     32'(min),     mi);
      check("sec",     32'(sec),     s);
      check("time_c",  32'(time_c),  32'(e_tc));
      check("alm_c",   32'(alm_c),   32'(e_ac));
      check("alm_on",  32'(alm_on),  32'(e_on));
      check("alm_off", 32'(alm_off), 32'(e_off));
      check("alm_en",  32'(alm_en),  32'(e_en));
      check("field",   32'(field),   exp_field());
      check("blink",   32'(blink),   exp_blink());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit bm, input bit bn, input bit bi, input bit ba);
    btn_mode = bm; btn_next = bn; btn_inc = bi; btn_alm = ba;
    @(posedge clk);
    model_step(bm, bn, bi, ba, rst);
    #1;
    btn_mode = 0; btn_next = 0; btn_inc = 0; btn_alm = 0;
  endtask

  task automatic mode_p();  tick(1, 0, 0, 0); endtask
  task automatic next_p();  tick(0, 1, 0, 0); endtask
  task automatic alm_p();   tick(0, 0, 0, 1); endtask
  task automatic inc_p(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  initial begin
    // Reset with running time 23:56:40.
    cur_hour = 6'd23; cur_min = 6'd56; cur_sec = 6'd40;
    rst = 1'b0;
    tick(0, 0, 0, 0);
    chk_en = 1'b1;
    tick(0, 0, 0, 0);
    check("rst_field", 32'(field), 0);
    check("rst_bus",   {14'd0, hour, min, sec}, 0);
    check("rst_alm_en", 32'(alm_en), 0);
    rst = 1'b1;
    idle(2);

    // Time set: 23:56:40 -> 0:59:40.
    mode_p();
    check("t_enter_field", 32'(field), 4);
    check("t_enter_hour",  32'(hour), 23);
    inc_p(1);
    check("t_hour_wrap", 32'(hour), 0);
    next_p();
    inc_p(3);
    check("t_min_59", 32'(min), 59);
    next_p();
    next_p();
    check("t_load_strobe", 32'(time_c), 1);
    check("t_load_bus", {14'd0, hour, min, sec}, {14'd0, 6'd0, 6'd59, 6'd40});
    idle(1);
    check("t_load_done_strobe", 32'(time_c), 0);
    check("t_load_done_field",  32'(field), 0);

    // Wrap behaviour from 22:58:58.
    cur_hour = 6'd22; cur_min = 6'd58; cur_sec = 6'd58;
    mode_p();
    inc_p(1);
    check("wrap_h23", 32'(hour), 23);
    inc_p(2);
    check("wrap_h1", 32'(hour), 1);
    next_p();
    inc_p(2);
    check("wrap_m0", 32'(min), 0);
    next_p();
    inc_p(2);
    check("wrap_s0", 32'(sec), 0);

    // Alarm set: second btn_mode enters A_HR with shadow 0:00:00.
    mode_p();
    check("a_enter_field", 32'(field), 4);
    check("a_enter_bus", {14'd0, hour, min, sec}, 0);
    check("a_enter_no_tc", 32'(time_c), 0);
    inc_p(7);
    next_p();
    inc_p(30);
    next_p();
    check("a_load_strobe", 32'(alm_c), 1);
    check("a_load_bus", {14'd0, hour, min, sec}, {14'd0, 6'd7, 6'd30, 6'd0});
    idle(1);
    mode_p();
    mode_p();
    check("a_reenter_bus", {14'd0, hour, min, sec}, {14'd0, 6'd7, 6'd30, 6'd0});
    mode_p();

    // Alarm enable toggling in IDLE, ignored while editing.
    alm_p();
    check("alm_on_pulse", {alm_on, alm_off, alm_en}, 3'b101);
    alm_p();
    check("alm_off_pulse", {alm_on, alm_off, alm_en}, 3'b010);
    alm_p();
    mode_p();
    next_p();
    alm_p();
    check("alm_in_edit", {alm_on, alm_off, alm_en, field}, {3'b001, 3'b010});

    // Timeout abort from a fresh T_MIN entry, with blink phase check.
    mode_p();
    mode_p();
    mode_p();
    next_p();
    idle(BLINK_DIV);
    check("blink_high", 32'(blink), 1);
    idle(TIMEOUT - 1 - BLINK_DIV);
    check("to_still_min", 32'(field), 2);
    idle(1);
    check("to_idle", {time_c, alm_c, field, blink}, 0);

    // btn_mode in A_MIN aborts the alarm edit.
    mode_p();
    mode_p();
    next_p();
    inc_p(1);
    mode_p();
    check("a_abort", {alm_c, field}, 0);
    idle(1);

    // Reset in T_SEC.
    mode_p();
    next_p();
    next_p();
    rst = 1'b0;
    tick(0, 0, 0, 0);
    rst = 1'b1;
    check("rst_mid_edit", {time_c, field, alm_en}, 0);
    check("rst_mid_bus", {14'd0, hour, min, sec}, 0);
    idle(1);

    // Priority: next beats inc; mode beats next.
    mode_p();
    tick(0, 1, 1, 0);
    check("pri_next_field", 32'(field), 2);
    check("pri_next_hour",  32'(hour), 22);
    next_p();
    tick(1, 1, 0, 0);
    check("pri_mode_field", 32'(field), 4);
    check("pri_mode_no_tc", 32'(time_c), 0);
    check("pri_mode_bus", {14'd0, hour, min, sec}, 0);
    idle(2);
    mode_p();
    idle(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
